// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader and 10-byte fetch window; optional IMEM_CHECKSUM_EN adds load_csum
module imem_loader #(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   input  logic              s_last,
   output logic              s_ready,
   output logic              loading,
   output logic              load_done,
   output logic              load_overflow,
   output logic [ADDR_W:0]   load_count,
`ifdef IMEM_CHECKSUM_EN
   output logic [7:0]        load_csum,
`endif
   input  logic [63:0]       F_pc,
   output logic [79:0]       f_bytes,
   output logic              imem_error
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] wptr;
   logic [7:0]        mem [MEM_BYTES];
   logic              xfer;
   logic              last_slot;

   assign s_ready   = (state == LOAD);
   assign loading   = (state == LOAD);
   assign load_done = (state == DONE);
   assign xfer      = s_valid && s_ready;
   assign last_slot = (wptr == ADDR_W'(MEM_BYTES - 1));

   // Load sequencer: start/restart clears, byte accounting and end-of-load detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wptr          <= '0;
         load_count    <= '0;
         load_overflow <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
         load_csum     <= 8'h00;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (load_start) begin
                  state         <= LOAD;
                  wptr          <= '0;
                  load_count    <= '0;
                  load_overflow <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                  load_csum     <= 8'h00;
`endif
               end
            end
            LOAD: begin
               if (xfer) begin
                  // Count saturates at MEM_BYTES; the overflow exit keeps it from going further anyway
                  if (load_count != (ADDR_W+1)'(MEM_BYTES))
                     load_count <= load_count + 1'b1;
`ifdef IMEM_CHECKSUM_EN
                  load_csum <= load_csum + s_data;
`endif
                  // The pointer parks on the top byte so it can never address past the array
                  if (!last_slot)
                     wptr <= wptr + 1'b1;
                  if (s_last) begin
                     state         <= DONE;
                     load_overflow <= 1'b0;
                  end else if (last_slot) begin
                     state         <= DONE;
                     load_overflow <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Program storage: written only on a stream transfer, never cleared by reset
   always_ff @(posedge clk) begin
      if (xfer)
         mem[wptr] <= s_data;
   end

   // Fetch window: zero-latency read, forced to zero whenever the window is invalid
   always_comb begin
      f_bytes    = '0;
      imem_error = (state != DONE) || (F_pc > 64'(MEM_BYTES - 10));
      if (!imem_error) begin
         for (int k = 0; k < 10; k++)
            f_bytes[8*k +: 8] = mem[F_pc[ADDR_W-1:0] + ADDR_W'(k)];
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed bench with a behavioural load/fetch model for imem_loader
module tb_imem_loader;

   localparam int MB = 16;
   localparam int AW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic        loading;
   logic        load_done;
   logic        load_overflow;
   logic [AW:0] load_count;
`ifdef IMEM_CHECKSUM_EN
   logic [7:0]  load_csum;
`endif
   logic [63:0] F_pc = 64'd0;
   logic [79:0] f_bytes;
   logic        imem_error;

   int n_chk = 0;
   int n_fail = 0;

   imem_loader #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
      .loading(loading), .load_done(load_done), .load_overflow(load_overflow),
      .load_count(load_count),
`ifdef IMEM_CHECKSUM_EN
      .load_csum(load_csum),
`endif
      .F_pc(F_pc), .f_bytes(f_bytes), .imem_error(imem_error)
   );

   always #5 clk = ~clk;

   // Behavioural model: phase 0 = idle, 1 = accepting bytes, 2 = program present
   int       m_phase = 0;
   int       m_count = 0;
   bit       m_ovf = 1'b0;
   bit [7:0] m_csum = 8'h00;
   bit [7:0] m_mem [MB];
   bit       m_known [MB];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_count <= 0;
         m_ovf   <= 1'b0;
         m_csum  <= 8'h00;
      end else if (m_phase != 1) begin
         if (load_start) begin
            m_phase <= 1;
            m_count <= 0;
            m_ovf   <= 1'b0;
            m_csum  <= 8'h00;
         end
      end else if (s_valid) begin
         m_mem[m_count]   <= s_data;
         m_known[m_count] <= 1'b1;
         m_count          <= m_count + 1;
         m_csum           <= m_csum + s_data;
         if (s_last) begin
            m_phase <= 2;
            m_ovf   <= 1'b0;
         end else if (m_count + 1 == MB) begin
            m_phase <= 2;
            m_ovf   <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Compare process: every cycle, mid-period, DUT outputs against the model
   always @(negedge clk) begin
      bit          e_err;
      bit          all_known;
      logic [79:0] e_bytes;
      e_err = (m_phase != 2) || (F_pc > 64'(MB - 10));
      chk("m_s_ready",   80'(s_ready),       80'(m_phase == 1));
      chk("m_loading",   80'(loading),       80'(m_phase == 1));
      chk("m_load_done", 80'(load_done),     80'(m_phase == 2));
      chk("m_overflow",  80'(load_overflow), 80'(m_ovf));
      chk("m_count",     80'(load_count),    80'(m_count));
      chk("m_imem_err",  80'(imem_error),    80'(e_err));
`ifdef IMEM_CHECKSUM_EN
      chk("m_csum",      80'(load_csum),     80'(m_csum));
`endif
      if (e_err) begin
         chk("m_f_bytes_zero", f_bytes, 80'd0);
      end else begin
         all_known = 1'b1;
         e_bytes   = '0;
         for (int k = 0; k < 10; k++) begin
            all_known = all_known && m_known[int'(F_pc) + k];
            e_bytes[8*k +: 8] = m_mem[int'(F_pc) + k];
         end
         if (all_known)
            chk("m_f_bytes", f_bytes, e_bytes);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      logic [7:0] prog [11];
      prog = '{8'h30, 8'h20, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      // Reset state
      tick();
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_imem_error", 80'(imem_error), 80'd1);
      chk("rst_f_bytes",    f_bytes,         80'd0);
      chk("rst_s_ready",    80'(s_ready),    80'd0);
      chk("rst_load_count", 80'(load_count), 80'd0);

      // 11-byte program, valid held high
      tick();
      start_load();
      s_valid = 1'b1;
      for (int i = 0; i < 11; i++) begin
         s_data = prog[i];
         s_last = (i == 10);
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      #1;
      chk("p11_load_done",  80'(load_done),     80'd1);
      chk("p11_load_count", 80'(load_count),    80'd11);
      chk("p11_f_lo16",     80'(f_bytes[15:0]), 80'h2030);
      chk("p11_imem_error", 80'(imem_error),    80'd0);

      // Gapped stream: valid only on even cycles
      tick();
      start_load();
      for (int i = 0; i < 8; i++) begin
         s_valid = (i % 2 == 0);
         s_data  = (i % 2 == 0) ? 8'(8'h10 + i / 2) : 8'hFF;
         s_last  = (i == 6);
         tick();
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      #1;
      chk("gap_load_count", 80'(load_count),    80'd4);
      chk("gap_f_lo32",     80'(f_bytes[31:0]), 80'h13121110);
`ifdef IMEM_CHECKSUM_EN
      chk("gap_csum",       80'(load_csum),     80'h46);
`endif

      // Overflow: 20 bytes, no last
      tick();
      start_load();
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h80 + i);
         tick();
      end
      s_valid = 1'b0;
      #1;
      chk("ovf_flag",       80'(load_overflow), 80'd1);
      chk("ovf_load_count", 80'(load_count),    80'd16);
      chk("ovf_s_ready",    80'(s_ready),       80'd0);
      F_pc = 64'd6;
      #1;
      chk("ovf_pc6_err",    80'(imem_error),    80'd0);
      chk("ovf_pc6_bytes",  f_bytes,            80'h8F8E8D8C8B8A89888786);
      F_pc = 64'd7;
      #1;
      chk("ovf_pc7_err",    80'(imem_error),    80'd1);
      F_pc = 64'h1_0000_0000;
      #1;
      chk("ovf_pchi_err",   80'(imem_error),    80'd1);
      chk("ovf_pchi_bytes", f_bytes,            80'd0);
      F_pc = 64'd0;

      // Reset mid-load, then a fresh 2-byte load
      tick();
      start_load();
      send(8'hA0, 1'b0);
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_load_count", 80'(load_count), 80'd0);
      chk("abort_load_done",  80'(load_done),  80'd0);
      chk("abort_imem_error", 80'(imem_error), 80'd1);
      tick();
      rst_n = 1'b1;
      tick();
      start_load();
      send(8'hB0, 1'b0);
      send(8'hB1, 1'b1);
      #1;
      chk("reload_count", 80'(load_count), 80'd2);
      chk("reload_done",  80'(load_done),  80'd1);

      // load_start in DONE with a byte offered: byte dropped, fresh LOAD follows
      tick();
      load_start = 1'b1;
      s_valid    = 1'b1;
      s_data     = 8'hEE;
      tick();
      load_start = 1'b0;
      s_valid    = 1'b0;
      #1;
      chk("restart_loading", 80'(loading),    80'd1);
      chk("restart_count",   80'(load_count), 80'd0);
      chk("restart_s_ready", 80'(s_ready),    80'd1);
      send(8'h55, 1'b1);
      #1;
      chk("restart_done",    80'(load_done),     80'd1);
      chk("restart_f_lo32",  80'(f_bytes[31:0]), 80'h83A2B155);

      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-memory front end that sits directly upstream of the Y86-64 fetch stage.
- Accepts a program as a byte stream over a valid/ready handshake and stores it in a byte-addressed instruction memory.
- Serves the 10-byte little-endian fetch window at F_pc to fetch, and flags imem_error.
- Fetch is only legal once a load has completed.

Parameters:
- MEM_BYTES, 1024, instruction memory size in bytes; must be at least 10.
- ADDR_W, 10, write-pointer width; must satisfy 2**ADDR_W >= MEM_BYTES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle request to begin a new program load
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_last  in  1  marks the final byte of the program
- s_ready  out  1  loader accepts a byte this cycle
- loading  out  1  FSM in LOAD
- load_done  out  1  FSM in DONE; fetch window valid
- load_overflow  out  1  last load was truncated at MEM_BYTES
- load_count  out  ADDR_W+1  bytes written by the current/last load
- F_pc  in  64  fetch address
- f_bytes  out  80  bytes F_pc..F_pc+9; f_bytes[7:0] = mem[F_pc]
- imem_error  out  1  fetch window invalid

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, s_ready=0, loading=0, load_done=0, load_overflow=0, load_count=0, wptr=0.
- Reset does not clear memory contents. Reset asserted mid-load aborts to IDLE; bytes already written are retained.
- FSM states: IDLE, LOAD, DONE. All outputs except f_bytes and imem_error are registered or state-decoded.
- IDLE:
  - s_ready=0.
  - load_start=1 → LOAD next cycle; wptr, load_count and load_overflow clear to 0 on that edge.
- LOAD:
  - s_ready=1 combinationally from state.
  - Handshake: a byte transfers on a clk edge where s_valid&&s_ready. It is written to mem[wptr]; wptr and load_count increment.
  - s_data and s_last are sampled only on transfer.
  - Transfer with s_last=1 → DONE next cycle; load_overflow=0.
  - Transfer at wptr==MEM_BYTES-1 with s_last=0 → DONE, load_overflow=1; s_ready drops the following cycle.
  - If that byte also has s_last=1, load_overflow=0.
  - load_start in LOAD is ignored.
- DONE:
  - s_ready=0; stream bytes are ignored and never written.
  - load_start=1 → LOAD, with the same clears as from IDLE.
  - Memory is not cleared, so bytes beyond the new load_count keep old contents.
- Fetch port (combinational, zero latency):
  - imem_error=1 when state!=DONE, or when F_pc > MEM_BYTES-10 (64-bit compare, so any nonzero upper bits also fault).
  - When imem_error=1, f_bytes=0.
  - Otherwise f_bytes[8k+7:8k] = mem[F_pc+k] for k=0..9.
  - Addresses within bounds but at or above load_count are not errors; they return stored contents.
- Width rules: load_count saturates at MEM_BYTES and never wraps; wptr never exceeds MEM_BYTES-1.
- Write and read of the same address in the same cycle cannot occur, because fetch is gated by DONE.

Optional Feature:
- Macro: IMEM_CHECKSUM_EN.
- When defined:
  - Adds output load_csum[7:0], reset 0, cleared on entry to LOAD.
  - Each transferred byte adds into it modulo 256, on the same edge as the write.
  - It holds its value in DONE.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset, then F_pc=0 → imem_error=1, f_bytes=0, s_ready=0, load_count=0.
- Load 30 20 05 00 00 00 00 00 00 00 00 (last on the 11th byte), with s_valid held high → exactly 11 transfers, load_done=1 the cycle after, load_count=11; F_pc=0 → f_bytes[15:0]=16'h2030, imem_error=0.
- Toggle s_valid every other cycle while loading 4 bytes 0x10..0x13 (last on 0x13) → only valid cycles transfer; load_count=4, mem[0..3]=10,11,12,13; with IMEM_CHECKSUM_EN defined, load_csum=0x46.
- With MEM_BYTES=16, stream 20 bytes with no s_last → 16 accepted, s_ready=0 afterwards, load_overflow=1, load_count=16; F_pc=6 → imem_error=0; F_pc=7 → imem_error=1; F_pc=64'h1_0000_0000 → imem_error=1.
- Assert rst_n low after 3 of 8 bytes → IDLE, load_count=0, load_done=0, imem_error=1; then a new load_start plus a 2-byte load → load_count=2, load_done=1.
- In DONE, pulse load_start together with s_valid=1 → no byte written that cycle; the next cycle is LOAD with load_count=0, s_ready=1.
